// File: rtl/audio_stream_arbiter.sv
// audio_stream_arbiter: round-robin burst arbiter sharing one audio sample sink between two sources, with an Avalon-MM control/status slave.
module audio_stream_arbiter #(
  parameter int DATA_SIZE = 28,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src0_valid,
  input  logic [DATA_SIZE-1:0] src0_data,
  output logic                 src0_ready,
  input  logic                 src1_valid,
  input  logic [DATA_SIZE-1:0] src1_data,
  output logic                 src1_ready,
  output logic                 sink_valid,
  output logic [DATA_SIZE-1:0] sink_data,
  output logic                 sink_id,
  input  logic                 sink_ready,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, state_nx;
  logic rr_ptr, rr_nx;
  logic [7:0] beat_cnt, beat_nx, burst;
  logic [1:0] enable;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic can_load, acc0, acc1, acc, req0, req1, cur, req_cur, req_oth, last, wr, unused_bits;
  assign unused_bits = ^writedata[31:8];
  assign can_load = !sink_valid | sink_ready;
  assign src0_ready = (state == GRANT0) & enable[0] & can_load;
  assign src1_ready = (state == GRANT1) & enable[1] & can_load;
  assign acc0 = src0_valid & src0_ready;
  assign acc1 = src1_valid & src1_ready;
  assign acc = acc0 | acc1;
  assign req0 = src0_valid & enable[0];
  assign req1 = src1_valid & enable[1];
  assign cur = state == GRANT1;
  assign req_cur = cur ? req1 : req0;
  assign req_oth = cur ? req0 : req1;
  // >= rather than == so a BURST lowered mid-burst ends it on the next accept
  assign last = acc & ({1'b0, beat_cnt} + 9'd1 >= {1'b0, burst});
  assign wr = chipselect & write;
  always_comb begin
    state_nx = state;
    rr_nx = rr_ptr;
    beat_nx = beat_cnt;
    if (state != GRANT0 && state != GRANT1) begin
      beat_nx = '0;
      state_nx = (req0 & req1) ? (rr_ptr ? GRANT1 : GRANT0) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
    end else if (last | !req_cur) begin
      rr_nx = !cur;
      beat_nx = '0;
      state_nx = req_oth ? (cur ? GRANT0 : GRANT1) : req_cur ? state : IDLE;
    end else begin
      beat_nx = beat_cnt + {7'd0, acc};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      beat_cnt <= '0;
      sink_valid <= 1'b0;
      sink_data <= '0;
      sink_id <= 1'b0;
      enable <= 2'b11;
      burst <= 8'd4;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_nx;
      beat_cnt <= beat_nx;
      if (acc) begin
        sink_valid <= 1'b1;
        sink_data <= acc1 ? src1_data : src0_data;
        sink_id <= acc1;
      end else if (sink_ready) begin
        sink_valid <= 1'b0;
      end
      if (wr && address == 2'd0) enable <= writedata[1:0];
      if (wr && address == 2'd1) burst <= (writedata[7:0] == 8'd0) ? 8'd1 : writedata[7:0];
      cnt0 <= (wr && address == 2'd2) ? '0 : cnt0 + CNT_W'(acc0);
      cnt1 <= (wr && address == 2'd3) ? '0 : cnt1 + CNT_W'(acc1);
    end
  end
  assign readdata = !(chipselect & read) ? 32'd0 :
                    (address == 2'd0) ? {30'd0, enable} :
                    (address == 2'd1) ? {24'd0, burst} :
                    (address == 2'd2) ? 32'(cnt0) : 32'(cnt1);
endmodule
